// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128/256 block encryptor, one round per clock
// Round keys are expanded on the fly from a single key register; valid/ready on both sides.
module aes_encrypt_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);

  localparam int         NR      = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] NR_LAST = 4'(NR);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    aes_sbox = SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [1:0]          r_fsm;
  logic [3:0]          r_round;
  logic [127:0]        r_state;
  logic [KEY_BITS-1:0] r_key;
  logic [127:0]        r_data_out;
  logic                r_out_valid;

  logic [127:0]        w_sb;
  logic [127:0]        w_sr;
  logic [127:0]        w_mc;
  logic [127:0]        w_rk_cur;
  logic [127:0]        w_round_out;
  logic [KEY_BITS-1:0] w_key_next;
  logic [31:0]         w_sw_in;
  logic [31:0]         w_sw_out;
  logic                w_in_ready;
  logic                w_accept;

  // SubBytes then ShiftRows: row r of column c takes the byte from column (c+r)%4.
  for (genvar g = 0; g < 16; g++) begin : g_bytes
    localparam int SRC = 4 * (((g / 4) + (g % 4)) % 4) + (g % 4);
    assign w_sb[127-8*g -: 8] = aes_sbox(r_state[127-8*g -: 8]);
    assign w_sr[127-8*g -: 8] = w_sb[127-8*SRC -: 8];
  end

  for (genvar gc = 0; gc < 4; gc++) begin : g_cols
    assign w_mc[127-32*gc -: 32] = mix_column(w_sr[127-32*gc -: 32]);
  end

  for (genvar gw = 0; gw < 4; gw++) begin : g_subword
    assign w_sw_out[31-8*gw -: 8] = aes_sbox(w_sw_in[31-8*gw -: 8]);
  end

  if (KEY_BITS == 128) begin : g_key128
    logic [31:0] w_temp, w_n0, w_n1, w_n2, w_n3;
    assign w_sw_in    = {r_key[23:0], r_key[31:24]};
    assign w_temp     = w_sw_out ^ {rcon(r_round), 24'h0};
    assign w_n0       = r_key[127:96] ^ w_temp;
    assign w_n1       = r_key[95:64]  ^ w_n0;
    assign w_n2       = r_key[63:32]  ^ w_n1;
    assign w_n3       = r_key[31:0]   ^ w_n2;
    assign w_rk_cur   = {w_n0, w_n1, w_n2, w_n3};
    assign w_key_next = w_rk_cur;
  end else if (KEY_BITS == 256) begin : g_key256
    // Register holds {rk[r-1], rk[r]}; this round uses rk[r] and derives rk[r+1].
    logic [3:0]  w_next_idx;
    logic        w_even;
    logic [31:0] w_temp, w_n0, w_n1, w_n2, w_n3;
    assign w_next_idx = r_round + 4'd1;
    assign w_even     = ~w_next_idx[0];
    assign w_sw_in    = w_even ? {r_key[23:0], r_key[31:24]} : r_key[31:0];
    assign w_temp     = w_sw_out ^ (w_even ? {rcon({1'b0, w_next_idx[3:1]}), 24'h0} : 32'h0);
    assign w_n0       = r_key[255:224] ^ w_temp;
    assign w_n1       = r_key[223:192] ^ w_n0;
    assign w_n2       = r_key[191:160] ^ w_n1;
    assign w_n3       = r_key[159:128] ^ w_n2;
    assign w_rk_cur   = r_key[127:0];
    assign w_key_next = {r_key[127:0], w_n0, w_n1, w_n2, w_n3};
  end else begin : g_key_bad
    $error("aes_encrypt_core: KEY_BITS must be 128 or 256");
  end

  assign w_round_out = ((r_round == NR_LAST) ? w_sr : w_mc) ^ w_rk_cur;

  always_comb begin
    w_in_ready = 1'b0;
    if (rst_n_in) begin
      case (r_fsm)
        ST_IDLE: w_in_ready = 1'b1;
        ST_DONE: w_in_ready = out_ready;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = in_valid & w_in_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fsm       <= ST_IDLE;
      r_round     <= 4'd0;
      r_state     <= '0;
      r_key       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= data_in ^ key_in[KEY_BITS-1 -: 128];
      r_key       <= key_in;
      r_round     <= 4'd1;
      r_fsm       <= ST_RUN;
      r_out_valid <= 1'b0;
    end else if (r_fsm == ST_RUN) begin
      r_state <= w_round_out;
      r_key   <= w_key_next;
      if (r_round == NR_LAST) begin
        r_data_out  <= w_round_out;
        r_out_valid <= 1'b1;
        r_fsm       <= ST_DONE;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end else if (r_fsm == ST_DONE) begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
        r_fsm       <= ST_IDLE;
      end
    end else begin
      r_fsm <= ST_IDLE;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign busy      = (r_fsm != ST_IDLE);

endmodule
